// File: rtl/timestamp_unit.sv
// timestamp_unit: cycle-counter profiler that queues command timestamps onto a 64-bit stream
module timestamp_unit #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  command,
  output logic        done,
  output logic [63:0] tsTDATA,
  output logic        tsTVALID,
  input  logic        tsTREADY,
  output logic        tsTLAST,
  output logic [15:0] dropped
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [63:0] cnt_q, cnt_d;
  logic [15:0] drop_q, drop_d;
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] count_q;
  logic [64:0] mem_q [DEPTH];
  logic [64:0] head;
  logic push, push_last, pop, clear;
  assign head = mem_q[rd_q];
  assign tsTVALID = count_q != '0;
  assign pop = tsTVALID && tsTREADY;
  assign tsTDATA = tsTVALID ? head[63:0] : '0;
  assign tsTLAST = tsTVALID && head[64];
  assign done = state_q == IDLE;
  assign dropped = drop_q;
  // Sequencing: the finish entry always fits because ordinary saves stop one slot short
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    drop_d = drop_q;
    push = 1'b0;
    push_last = 1'b0;
    clear = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d = '0;
        drop_d = '0;
        clear = 1'b1;
      end
      RUN: begin
        cnt_d = cnt_q + 64'd1;
        if (command == 4'h1) begin
          push = count_q < LIMIT;
          drop_d = count_q < LIMIT ? drop_q : drop_q + 16'(drop_q != 16'hFFFF);
        end else if (command == 4'h2) begin
          push = 1'b1;
          push_last = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = pop && head[64] ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // Control state, cycle counter and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
    end
  end
  // FIFO pointers and occupancy; a start flushes anything left over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // FIFO storage; contents are only observed while occupancy is non-zero
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {push_last, cnt_q};
  end
endmodule

// File: tb/tb_timestamp_unit.sv
// tb_timestamp_unit: directed vectors and corner sequences for timestamp_unit
module tb_timestamp_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic tsTREADY = 1'b0;
  logic [3:0] command = 4'h0;
  logic done, tsTVALID, tsTLAST;
  logic [63:0] tsTDATA;
  logic [15:0] dropped;
  int n_cmp = 0;
  int n_err = 0;
  logic [64:0] got[$];
  logic [64:0] exp_q[$];
  bit chk_stable = 0;

  always #5 clk = ~clk;

  timestamp_unit dut (
    .clk(clk), .rst(rst), .start(start), .command(command), .done(done),
    .tsTDATA(tsTDATA), .tsTVALID(tsTVALID), .tsTREADY(tsTREADY),
    .tsTLAST(tsTLAST), .dropped(dropped)
  );

  typedef struct {
    logic st; logic [3:0] cmd; logic rdy;
    logic e_done; logic e_valid; logic [63:0] e_data; logic e_last; logic [15:0] e_drop;
  } vec_t;
  vec_t vecs[13];

  function automatic logic [64:0] beat(input logic last, input logic [63:0] data);
    return {last, data};
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    logic stall;
    logic [64:0] prev;
    stall = tsTVALID && !tsTREADY;
    prev = {tsTLAST, tsTDATA};
    if (tsTVALID && tsTREADY) got.push_back({tsTLAST, tsTDATA});
    @(posedge clk);
    @(negedge clk);
    if (chk_stable && stall) chk("stall_hold", {tsTLAST, tsTDATA}, prev);
  endtask

  task automatic start_run();
    start = 1'b1;
    command = 4'h0;
    cyc();
    start = 1'b0;
    got.delete();
  endtask

  task automatic drain(input string name, input bit rnd);
    int n;
    n = 0;
    command = 4'h0;
    while (!done && n < 80) begin
      tsTREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      n++;
    end
    chk({name, "_done"}, 65'(done), 65'(1));
  endtask

  task automatic check_beats(input string name);
    chk({name, "_count"}, 65'(got.size()), 65'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", name, i), got[i], exp_q[i]);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 64'd0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 64'd0, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 4'h5, 1'b1, 1'b0, 1'b1, 64'd2, 1'b0, 16'd0};
    vecs[5]  = '{1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 64'd4, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 64'd4, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 64'd4, 1'b0, 16'd0};
    vecs[8]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 64'd5, 1'b1, 16'd0};
    vecs[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 64'd5, 1'b1, 16'd0};
    vecs[10] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 16'd0};
    vecs[11] = '{1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 16'd0};
    vecs[12] = '{1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 16'd0};

    repeat (2) @(negedge clk);
    chk("rst_done", 65'(done), 65'(1));
    chk("rst_valid", 65'(tsTVALID), 65'(0));
    chk("rst_beat", {tsTLAST, tsTDATA}, 65'(0));
    chk("rst_drop", 65'(dropped), 65'(0));
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 13; i++) begin
      start = vecs[i].st;
      command = vecs[i].cmd;
      tsTREADY = vecs[i].rdy;
      cyc();
      chk($sformatf("vec%0d_done", i), 65'(done), 65'(vecs[i].e_done));
      chk($sformatf("vec%0d_valid", i), 65'(tsTVALID), 65'(vecs[i].e_valid));
      chk($sformatf("vec%0d_data", i), 65'(tsTDATA), 65'(vecs[i].e_data));
      chk($sformatf("vec%0d_last", i), 65'(tsTLAST), 65'(vecs[i].e_last));
      chk($sformatf("vec%0d_drop", i), 65'(dropped), 65'(vecs[i].e_drop));
    end
    start = 1'b0;
    command = 4'h0;

    // basic run: saves at 3 and 10, finish at 20
    tsTREADY = 1'b1;
    start_run();
    for (int j = 0; j <= 20; j++) begin
      command = (j == 3 || j == 10) ? 4'h1 : (j == 20) ? 4'h2 : 4'h0;
      cyc();
    end
    command = 4'h0;
    chk("basic_fin_head", {tsTLAST, tsTDATA}, beat(1'b1, 64'd20));
    chk("basic_done_pre", 65'(done), 65'(0));
    cyc();
    chk("basic_done", 65'(done), 65'(1));
    chk("basic_drop", 65'(dropped), 65'(0));
    exp_q = '{beat(1'b0, 64'd3), beat(1'b0, 64'd10), beat(1'b1, 64'd20)};
    check_beats("basic_beats");

    // overflow: ten saves into a stalled FIFO, then finish
    tsTREADY = 1'b0;
    start_run();
    for (int j = 0; j < 10; j++) begin
      command = 4'h1;
      cyc();
    end
    command = 4'h2;
    cyc();
    chk("ovf_drop", 65'(dropped), 65'(3));
    chk("ovf_head", {tsTLAST, tsTDATA}, beat(1'b0, 64'd0));
    drain("ovf", 1'b0);
    exp_q.delete();
    for (int k = 0; k < 7; k++) exp_q.push_back(beat(1'b0, 64'(k)));
    exp_q.push_back(beat(1'b1, 64'd10));
    check_beats("ovf_beats");
    chk("ovf_drop_idle", 65'(dropped), 65'(3));

    // boundary: count at limit with a pop in the same cycle
    tsTREADY = 1'b0;
    start_run();
    for (int j = 0; j < 7; j++) begin
      command = 4'h1;
      cyc();
    end
    tsTREADY = 1'b1;
    command = 4'h1;
    cyc();
    chk("bnd_drop", 65'(dropped), 65'(1));
    chk("bnd_head", {tsTLAST, tsTDATA}, beat(1'b0, 64'd1));
    tsTREADY = 1'b0;
    cyc();
    tsTREADY = 1'b1;
    command = 4'h2;
    cyc();
    chk("bnd_fin_drop", 65'(dropped), 65'(1));
    chk("bnd_fin_state", 65'(done), 65'(0));
    drain("bnd", 1'b0);
    exp_q.delete();
    for (int k = 0; k < 7; k++) exp_q.push_back(beat(1'b0, 64'(k)));
    exp_q.push_back(beat(1'b0, 64'd8));
    exp_q.push_back(beat(1'b1, 64'd9));
    check_beats("bnd_beats");

    // backpressure: random ready during a five-sample run
    chk_stable = 1;
    tsTREADY = 1'($urandom_range(0, 1));
    start_run();
    for (int j = 0; j <= 8; j++) begin
      tsTREADY = 1'($urandom_range(0, 1));
      command = (j == 1 || j == 3 || j == 4 || j == 6) ? 4'h1 : (j == 8) ? 4'h2 : 4'h0;
      cyc();
    end
    drain("bp", 1'b1);
    chk_stable = 0;
    exp_q = '{beat(1'b0, 64'd1), beat(1'b0, 64'd3), beat(1'b0, 64'd4),
              beat(1'b0, 64'd6), beat(1'b1, 64'd8)};
    check_beats("bp_beats");

    // reset while draining with four entries queued
    tsTREADY = 1'b0;
    start_run();
    for (int j = 0; j < 9; j++) begin
      command = 4'h1;
      cyc();
    end
    tsTREADY = 1'b1;
    command = 4'h0;
    repeat (4) cyc();
    tsTREADY = 1'b0;
    command = 4'h2;
    cyc();
    command = 4'h0;
    chk("mid_head", {tsTLAST, tsTDATA}, beat(1'b0, 64'd4));
    chk("mid_drop", 65'(dropped), 65'(2));
    chk("mid_done", 65'(done), 65'(0));
    rst = 1'b1;
    #1;
    chk("mid_rst_async_valid", 65'(tsTVALID), 65'(0));
    chk("mid_rst_async_done", 65'(done), 65'(1));
    cyc();
    chk("mid_rst_valid", 65'(tsTVALID), 65'(0));
    chk("mid_rst_done", 65'(done), 65'(1));
    chk("mid_rst_drop", 65'(dropped), 65'(0));
    chk("mid_rst_beat", {tsTLAST, tsTDATA}, 65'(0));
    rst = 1'b0;
    tsTREADY = 1'b1;
    got.delete();
    repeat (3) cyc();
    chk("post_rst_quiet", 65'(got.size()), 65'(0));
    chk("post_rst_done", 65'(done), 65'(1));
    start_run();
    command = 4'h1;
    cyc();
    command = 4'h2;
    cyc();
    drain("post", 1'b0);
    exp_q = '{beat(1'b0, 64'd0), beat(1'b1, 64'd1)};
    check_beats("post_beats");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/timestamp_unit.md
TIMESTAMP_UNIT -- requirements
Module: timestamp_unit

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, >= 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  begins a profiling run; sampled in IDLE only.
REQ-005 command  input  4  per-cycle command from the command stage: 0x0 NOP, 0x1 save timestamp, 0x2 finish; other values are NOP.
REQ-006 done  output  1  high while in IDLE.
REQ-007 tsTDATA  output  64  timestamp stream data, taken from the FIFO head.
REQ-008 tsTVALID  output  1  stream valid; high whenever the FIFO is non-empty.
REQ-009 tsTREADY  input  1  stream ready from the consumer.
REQ-010 tsTLAST  output  1  marks the final (finish) timestamp of a run.
REQ-011 dropped  output  16  count of 0x1 commands lost to a full FIFO in the current run.

Function
REQ-012 FSM states: IDLE, RUN, DRAIN; encoding is free.
REQ-013 IDLE: start=1 -> RUN next cycle; cycle counter cleared to 0, dropped cleared to 0, FIFO emptied.
REQ-014 Cycle counter: 64-bit; reads 0 in the first RUN cycle; +1 every RUN cycle; wraps 0xFFFF_FFFF_FFFF_FFFF -> 0; holds in IDLE and DRAIN.
REQ-015 Timestamp value: the counter value in the cycle the command is sampled.
REQ-016 RUN, command=0x1, FIFO count < DEPTH-1: push {last=0, counter}.
REQ-017 RUN, command=0x1, FIFO count >= DEPTH-1: no push; dropped +1, saturating at 0xFFFF.
REQ-018 Last slot: one FIFO slot is always reserved for the finish entry.
REQ-019 RUN, command=0x2: push {last=1, counter}; state -> DRAIN. This push always succeeds (see REQ-018).
REQ-020 command is ignored in IDLE and DRAIN; start is ignored outside IDLE.
REQ-021 Stream handshake: a pop occurs on any cycle with tsTVALID=1 and tsTREADY=1.
REQ-022 Stream stability: while tsTVALID=1 and tsTREADY=0, tsTDATA and tsTLAST hold stable.
REQ-023 tsTLAST equals the last flag of the head entry.
REQ-024 Push latency: an entry pushed at cycle N is visible on the stream at cycle N+1 at the earliest (registered FIFO, first-word fall-through).
REQ-025 Simultaneous push and pop in the same cycle: both take effect; count is unchanged; order is preserved.
REQ-026 Full and pop in the same cycle: a 0x1 push in a cycle where count = DEPTH-1 and a pop also occurs is dropped; the limit is checked on the pre-pop count.
REQ-027 DRAIN: when the beat with tsTLAST=1 completes its handshake -> IDLE next cycle; done rises that cycle.
REQ-028 DRAIN dropped value: dropped holds its final value through DRAIN and IDLE until the next start.

Reset
REQ-029 rst=1 at any time, including mid-RUN or mid-DRAIN, immediately forces all of the following:
- state=IDLE
- FIFO empty
- counter=0
- dropped=0
- tsTVALID=0, tsTLAST=0, tsTDATA=0
- done=1
REQ-030 After rst deasserts, the block waits in IDLE for start; no stream beats are emitted before start.

Verification
REQ-031 Basic run: start; tsTREADY=1; 0x1 at counter 3 and 10; 0x2 at 20 -> beats 3, 10, 20 with tsTLAST only on 20; done=1 one cycle after the 20 handshake; dropped=0.
REQ-032 Overflow (DEPTH=8): tsTREADY=0; ten 0x1 commands, then 0x2 -> 7 entries plus finish stored, dropped=3; raise tsTREADY -> exactly 8 beats in push order, last beat tsTLAST=1.
REQ-033 Backpressure: toggle tsTREADY randomly during a 5-sample run -> tsTDATA/tsTLAST stable while stalled; no loss, no duplication.
REQ-034 Boundary: count=DEPTH-1 with a pop and a 0x1 in the same cycle -> push dropped, dropped increments; a 0x2 in the same situation is accepted.
REQ-035 Reset mid-DRAIN with 4 entries queued -> next cycle tsTVALID=0, done=1, dropped=0; a later start begins with counter=0.
REQ-036 Ignored inputs: 0x1/0x2 in IDLE, command 0x5 in RUN, start in RUN -> no pushes, no state change.
